fritz_bist_array: RTL and testbench

FRITZ_BIST_ARRAY -- requirements
Module: fritz_bist_array

---
 rtl/fritz_bist_pkg.sv | 26 ++
 rtl/fritz_lane.sv | 19 +
 rtl/fritz_bist_array.sv | 141 ++++++++++++++
 tb/tb_fritz_bist_array.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fritz_bist_pkg.sv
// Shared types and constants for the fritz_bist_array self-testing logic array:
// FSM states, LFSR/MISR polynomial and the default LFSR seed.
package fritz_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK
  } state_e;

  localparam int MISR_W = 16;
  localparam logic [MISR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // x^16+x^14+x^13+x^11+1 as a tap mask over q[15], q[13], q[12], q[10].
  localparam logic [MISR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [MISR_W-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

  function automatic logic [MISR_W-1:0] lfsr_step(input logic [MISR_W-1:0] q);
    return {q[MISR_W-2:0], lfsr_fb(q)};
  endfunction

endpackage

// File: rtl/fritz_lane.sv
// One 4-in/3-out combinational logic lane: g = {G4,G3,G2,G1}, y = {G7,G6,G5}.
module fritz_lane (
  input  logic [3:0] g,
  output logic [2:0] y
);

  logic w1, w2, w3, w4, w5;

  assign w1 = ~(g[0] & g[1]);
  assign w2 = ~(g[1] | g[2]);
  assign w3 = g[2] & g[3];
  assign w4 = w1 & w2;
  assign w5 = w2 | w3;

  assign y[0] = g[0] | w4;
  assign y[1] = w4 & w5;
  assign y[2] = ~(w5 | g[3]);

endmodule

// File: rtl/fritz_bist_array.sv
// LANES-wide two-stage logic pipeline with a built-in self-test: an LFSR
// replaces the functional input while a MISR compacts the lane results.
module fritz_bist_array
  import fritz_bist_pkg::*;
#(
  parameter int unsigned       LANES    = 8,
  parameter int unsigned       BIST_LEN = 255,
  parameter logic [MISR_W-1:0] SEED     = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [4*LANES-1:0]   in_data,
  output logic                 out_valid,
  output logic [3*LANES-1:0]   out_data,
  input  logic                 bist_start,
  input  logic [MISR_W-1:0]    golden_sig,
  output logic                 busy,
  output logic                 bist_done,
  output logic                 bist_pass
);

  localparam logic [15:0] LAST_PAT = 16'(BIST_LEN - 1);

  state_e              state_q, state_d;
  logic [MISR_W-1:0]   lfsr_q, misr_q;
  logic [15:0]         cnt_q;
  logic                drain_q;

  logic                mux_valid, mux_bist;
  logic [4*LANES-1:0]  mux_data, bist_pattern;

  logic                s1_valid_q, s1_bist_q;
  logic [4*LANES-1:0]  s1_data_q;
  logic [3*LANES-1:0]  lane_res;

  logic                bres_valid_q;
  logic [3*LANES-1:0]  bres_q;
  logic [MISR_W-1:0]   fold;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign bist_pattern[4*i +: 4] = lfsr_q[4*(i%4) +: 4];

    fritz_lane u_lane (
      .g (s1_data_q[4*i +: 4]),
      .y (lane_res[3*i +: 3])
    );
  end

  assign busy = (state_q != ST_IDLE);

  // NOTE: every variable gets a default before the case so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mux_data  = in_data;
    mux_valid = in_valid & (state_q == ST_IDLE);
    mux_bist  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (bist_start) state_d = ST_RUN;
      ST_RUN: begin
        mux_data  = bist_pattern;
        mux_valid = 1'b1;
        mux_bist  = 1'b1;
        if (cnt_q == LAST_PAT) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (drain_q) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output bit j lands on signature bit j mod 16.
  always_comb begin
    fold = '0;
    for (int j = 0; j < 3*LANES; j++) begin
      fold[4'(j % MISR_W)] = fold[4'(j % MISR_W)] ^ bres_q[j];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == ST_DRAIN) ? ~drain_q : 1'b0;
      if (state_q == ST_IDLE && bist_start) begin
        lfsr_q <= SEED;
        misr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (state_q == ST_RUN) begin
          lfsr_q <= lfsr_step(lfsr_q);
          cnt_q  <= (cnt_q == LAST_PAT) ? 16'd0 : cnt_q + 16'd1;
        end
        if (bres_valid_q && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
          misr_q <= lfsr_step(misr_q) ^ fold;
        end
      end
    end
  end

  // Functional and self-test results share the lane logic but land in
  // separate output registers so out_data only changes on out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_bist_q    <= 1'b0;
      s1_data_q    <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      bres_valid_q <= 1'b0;
      bres_q       <= '0;
    end else begin
      s1_valid_q   <= mux_valid;
      s1_bist_q    <= mux_bist;
      if (mux_valid) s1_data_q <= mux_data;
      out_valid    <= s1_valid_q & ~s1_bist_q;
      bres_valid_q <= s1_valid_q & s1_bist_q;
      if (s1_valid_q && !s1_bist_q) out_data <= lane_res;
      if (s1_valid_q && s1_bist_q)  bres_q   <= lane_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bist_done <= 1'b0;
      bist_pass <= 1'b0;
    end else begin
      bist_done <= (state_q == ST_CHECK);
      if (state_q == ST_CHECK) bist_pass <= (misr_q == golden_sig);
    end
  end

endmodule

// File: tb/tb_fritz_bist_array.sv
// Directed bench for fritz_bist_array: lane truth values, pipeline timing,
// and self-test runs against a signature computed by a behavioural model.
module tb_fritz_bist_array;

  localparam int          LANES    = 8;
  localparam int          BIST_LEN = 255;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic [4*LANES-1:0]  in_data;
  logic                out_valid;
  logic [3*LANES-1:0]  out_data;
  logic                bist_start;
  logic [15:0]         golden_sig;
  logic                busy;
  logic                bist_done;
  logic                bist_pass;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sig;

  always #5 clk = ~clk;

  fritz_bist_array #(
    .LANES    (LANES),
    .BIST_LEN (BIST_LEN),
    .SEED     (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .bist_start (bist_start),
    .golden_sig (golden_sig),
    .busy       (busy),
    .bist_done  (bist_done),
    .bist_pass  (bist_pass)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reduced form of the lane equations: G5=a|~b~c, G6=~b~c, G7=~d(b|c).
  function automatic logic [2:0] model_lane(input logic [3:0] n);
    logic a, b, c, d;
    {d, c, b, a} = n;
    return {~d & (b | c), ~b & ~c, a | (~b & ~c)};
  endfunction

  function automatic logic [15:0] model_sig();
    logic [15:0] l = SEED;
    logic [15:0] m = 16'h0000;
    logic [23:0] r;
    for (int p = 0; p < BIST_LEN; p++) begin
      for (int i = 0; i < LANES; i++) r[3*i +: 3] = model_lane(l[4*(i%4) +: 4]);
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ (r[15:0] ^ {8'h00, r[23:16]});
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return m;
  endfunction

  task automatic run_bist(input string tag, input logic [15:0] golden, input bit hold_start,
                          input bit xfer, input bit poke, input logic exp_pass);
    int busy_n = 0;
    int ov_n   = 0;
    bit done   = 1'b0;
    logic [23:0] ov_data = '0;
    golden_sig = golden;
    bist_start = 1'b1;
    in_valid   = xfer;
    in_data    = 32'hFFFF_FFFF;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (!hold_start) bist_start = 1'b0;
      in_valid = poke && (c % 7 == 3);
      in_data  = 32'h1234_5678;
      if (bist_done) done = 1'b1;
      else begin
        if (busy) busy_n++;
        if (out_valid) begin
          ov_n++;
          ov_data = out_data;
        end
      end
    end
    in_valid = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, busy_n, 32'd258);
    check({tag, "_out_valid_count"}, ov_n, xfer ? 32'd1 : 32'd0);
    if (xfer) check({tag, "_xfer_data"}, ov_data, 24'o11111111);
    check({tag, "_pass"}, 32'(bist_pass), 32'(exp_pass));
    if (!hold_start) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bist_done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  logic [31:0] vin  [6];
  logic [23:0] vexp [6];

  initial begin
    vin[0] = 32'h0000_0000; vexp[0] = 24'o33333333;
    vin[1] = 32'hFFFF_FFFF; vexp[1] = 24'o11111111;
    vin[2] = 32'h4444_4444; vexp[2] = 24'o44444444;
    vin[3] = 32'h7654_3210; vexp[3] = 24'o54545433;
    vin[4] = 32'hFEDC_BA98; vexp[4] = 24'o10101033;
    vin[5] = 32'h0000_0000; vexp[5] = 24'o33333333;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    bist_start = 1'b0;
    golden_sig = '0;
    sig        = model_sig();

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(bist_done), 32'd0);
    check("rst_pass", 32'(bist_pass), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back functional vectors, each result due two cycles later.
    for (int k = 0; k <= 6; k++) begin
      in_valid = (k < 6);
      in_data  = (k < 6) ? vin[k] : '0;
      @(negedge clk);
      if (k >= 1) begin
        check($sformatf("vec%0d_valid", k-1), 32'(out_valid), 32'd1);
        check($sformatf("vec%0d_data", k-1), out_data, vexp[k-1]);
      end
    end
    @(negedge clk);
    check("hold_valid", 32'(out_valid), 32'd0);
    check("hold_data", out_data, vexp[5]);

    run_bist("run_xfer", sig, 1'b0, 1'b1, 1'b0, 1'b1);

    // Abort at pattern 100.
    golden_sig = sig;
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pass", 32'(bist_pass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int done_n = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (bist_done) done_n++;
      end
      check("abort_no_done", done_n, 32'd0);
    end

    run_bist("run_after_rst", sig, 1'b0, 1'b0, 1'b0, 1'b1);
    run_bist("run_bad_golden", sig ^ 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    run_bist("b2b_first", sig, 1'b1, 1'b0, 1'b0, 1'b1);
    run_bist("b2b_second", sig, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
